// File: rtl/tilexy_cl_resp.sv
// Destination-tile cache-line responder: buffers popped mesh requests, runs them in order against the local bank,
// returns one response per request. Define TILEXY_RSP_WRACK_EN to acknowledge writes with WACK (otherwise posted).
module tilexy_cl_resp #(
  parameter logic [4:0]  TILE_X = 5'd0,
  parameter logic [4:0]  TILE_Y = 5'd0,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TMO    = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_avail,
  output logic         req_pop,
  input  logic [527:0] req_data,
  input  logic [36:0]  req_addr,
  input  logic [11:0]  req_size,
  input  logic [9:0]   req_src,
  output logic         bank_req,
  output logic         bank_we,
  output logic [26:0]  bank_addr,
  output logic [527:0] bank_wdata,
  input  logic         bank_ready,
  input  logic         bank_rvalid,
  input  logic [527:0] bank_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [4:0]   rsp_TX,
  output logic [4:0]   rsp_TY,
  output logic [9:0]   rsp_src,
  output logic [26:0]  rsp_addr,
  output logic [1:0]   rsp_kind,
  output logic [527:0] rsp_data,
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  logic [527:0] fifo_data_q [DEPTH];
  logic [26:0]  fifo_line_q [DEPTH];
  logic         fifo_we_q   [DEPTH];
  logic [9:0]   fifo_src_q  [DEPTH];

  state_e         state_q, state_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     tmo_q, tmo_d;
  logic [1:0]     rsp_kind_q, rsp_kind_d;
  logic [527:0]   rsp_data_q;
  logic           cur_we_q;
  logic [26:0]    cur_line_q;
  logic [527:0]   cur_wdata_q;
  logic [9:0]     cur_src_q;
  logic           full, have, deq, rdata_ld, data_clr;
  logic           unused_req;

  assign unused_req = ^{req_addr[36:27], req_size[11], req_size[9:0]};

  assign full    = (count_q == CW'(DEPTH));
  assign have    = (count_q != '0);
  assign req_pop = rst & req_avail & ~full;
  assign count_d = count_q + CW'(req_pop) - CW'(deq);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rsp_kind_d = rsp_kind_q;
    deq        = 1'b0;
    rdata_ld   = 1'b0;
    data_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (have) begin
          deq     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bank_ready) begin
          if (cur_we_q) begin
`ifdef TILEXY_RSP_WRACK_EN
            state_d    = S_RESP;
            rsp_kind_d = 2'd1;
            data_clr   = 1'b1;
`else
            deq     = have;
            state_d = have ? S_ISSUE : S_IDLE;
`endif
          end else begin
            state_d = S_WAIT;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // rvalid takes priority over a timeout expiring in the same cycle
        if (bank_rvalid) begin
          state_d    = S_RESP;
          rsp_kind_d = 2'd0;
          rdata_ld   = 1'b1;
        end else if (({1'b0, tmo_q} + 9'd1) == 9'(TMO)) begin
          state_d    = S_RESP;
          rsp_kind_d = 2'd2;
          data_clr   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          deq     = have;
          state_d = have ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      rsp_kind_q  <= '0;
      rsp_data_q  <= '0;
      cur_we_q    <= 1'b0;
      cur_line_q  <= '0;
      cur_wdata_q <= '0;
      cur_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      rsp_kind_q <= rsp_kind_d;
      if (req_pop) wptr_q <= wptr_q + 1'b1;
      if (deq) begin
        rptr_q      <= rptr_q + 1'b1;
        cur_we_q    <= fifo_we_q[rptr_q];
        cur_line_q  <= fifo_line_q[rptr_q];
        cur_wdata_q <= fifo_data_q[rptr_q];
        cur_src_q   <= fifo_src_q[rptr_q];
      end
      if (rdata_ld) rsp_data_q <= bank_rdata;
      else if (data_clr) rsp_data_q <= '0;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (req_pop) begin
      fifo_data_q[wptr_q] <= req_data;
      fifo_line_q[wptr_q] <= req_addr[26:0];
      fifo_we_q[wptr_q]   <= req_size[10];
      fifo_src_q[wptr_q]  <= req_src;
    end
  end

  assign bank_req   = (state_q == S_ISSUE);
  assign bank_we    = cur_we_q;
  assign bank_addr  = cur_line_q;
  assign bank_wdata = cur_wdata_q;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_TX    = cur_src_q[4:0];
  assign rsp_TY    = cur_src_q[9:5];
  assign rsp_src   = rsp_valid ? {TILE_Y, TILE_X} : 10'd0;
  assign rsp_addr  = cur_line_q;
  assign rsp_kind  = rsp_kind_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = have | (state_q != S_IDLE);
endmodule

// File: tb/tb_tilexy_cl_resp.sv
// Scoreboard bench for tilexy_cl_resp: random and directed requests, a bank model, and an in-order expectation queue.
module tb_tilexy_cl_resp;
  localparam logic [4:0] TX_P = 5'd9;
  localparam logic [4:0] TY_P = 5'd17;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_avail, req_pop;
  logic [527:0] req_data;
  logic [36:0] req_addr;
  logic [11:0] req_size;
  logic [9:0] req_src;
  logic bank_req, bank_we, bank_ready, bank_rvalid;
  logic [26:0] bank_addr;
  logic [527:0] bank_wdata, bank_rdata;
  logic rsp_valid, rsp_ready;
  logic [4:0] rsp_TX, rsp_TY;
  logic [9:0] rsp_src;
  logic [26:0] rsp_addr;
  logic [1:0] rsp_kind;
  logic [527:0] rsp_data;
  logic busy;

  tilexy_cl_resp #(.TILE_X(TX_P), .TILE_Y(TY_P), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_avail(req_avail), .req_pop(req_pop), .req_data(req_data), .req_addr(req_addr),
    .req_size(req_size), .req_src(req_src),
    .bank_req(bank_req), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_ready(bank_ready), .bank_rvalid(bank_rvalid), .bank_rdata(bank_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_TX(rsp_TX), .rsp_TY(rsp_TY),
    .rsp_src(rsp_src), .rsp_addr(rsp_addr), .rsp_kind(rsp_kind), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   kind;
    logic [4:0]   tx;
    logic [4:0]   ty;
    logic [26:0]  addr;
    logic [527:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   acc_cyc_q[$];
  logic [527:0] mem_m [int];
  logic [527:0] mem_b [int];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_popped = 0, n_rsp = 0, n_bank_acc = 0;
  int acc_cyc = 0, rise_cyc = 0;
  int brdy_mode = 1, rrdy_mode = 1;
  logic [4:0]   last_tx, last_ty;
  logic [9:0]   last_src;
  logic [527:0] last_wr_data;
  logic [26:0]  last_wr_addr;

  always @(posedge clk) cyc++;

  function automatic logic [527:0] init_val(input logic [26:0] l);
    return {16{l, 6'h2A}};
  endfunction

  function automatic logic [527:0] rand528();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[527:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Offer one request; returns once the DUT pops it, recording the expected outcome.
  task automatic send(input logic we, input logic [26:0] line, input logic [9:0] src,
                      input logic [527:0] data, input int d);
    int n;
    logic [9:0] hi;
    logic [9:0] msk;
    exp_t e;
    hi = 10'($urandom);
    msk = 10'($urandom);
    req_avail = 1'b1;
    req_addr  = {hi, line};
    req_size  = {~we, we, msk};
    req_src   = src;
    req_data  = data;
    n = 0;
    #1;
    while (!req_pop && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (!req_pop) begin
      check("pop_timeout", 64'(req_pop), 64'd1);
      @(negedge clk);
      req_avail = 1'b0;
      return;
    end
    n_popped++;
    e.tx = src[4:0];
    e.ty = src[9:5];
    e.addr = line;
    if (we) begin
      mem_m[int'(line)] = data;
`ifdef TILEXY_RSP_WRACK_EN
      e.kind = 2'd1;
      e.data = '0;
      exp_q.push_back(e);
`endif
    end else begin
      delay_q.push_back(d);
      if (d == 0) begin
        e.kind = 2'd2;
        e.data = '0;
      end else begin
        e.kind = 2'd0;
        e.data = mem_m.exists(int'(line)) ? mem_m[int'(line)] : init_val(line);
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_avail = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    check({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Bank model: separate memory, per-read rvalid delay taken in issue order (0 = never answers).
  initial begin
    int cnt, d;
    logic pend;
    logic [26:0] pline;
    pend = 1'b0; cnt = 0; pline = '0;
    bank_ready = 1'b0; bank_rvalid = 1'b0; bank_rdata = '0;
    forever begin
      @(negedge clk);
      bank_rvalid = 1'b0;
      bank_rdata  = rand528();
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          bank_rvalid = 1'b1;
          bank_rdata = mem_b.exists(int'(pline)) ? mem_b[int'(pline)] : init_val(pline);
        end
      end
      case (brdy_mode)
        0: bank_ready = ($urandom_range(0, 3) != 0);
        1: bank_ready = 1'b1;
        default: bank_ready = 1'b0;
      endcase
      if (bank_req && bank_ready) begin
        n_bank_acc++;
        acc_cyc = cyc;
        if (bank_we) begin
          mem_b[int'(bank_addr)] = bank_wdata;
          last_wr_data = bank_wdata;
          last_wr_addr = bank_addr;
        end else begin
          if (delay_q.size() == 0) begin
            check("bank_unexpected_read", 64'(bank_addr), 64'h7FFFFFF);
            d = 0;
          end else d = delay_q.pop_front();
          if (d > 0) begin
            pend = 1'b1; cnt = d; pline = bank_addr;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every accepted response; checks hold-stability.
  initial begin
    logic pv, pa, prst;
    logic [1:0] pk; logic [4:0] ptx, pty; logic [26:0] pad; logic [527:0] pdt;
    exp_t e;
    pv = 0; pa = 0; prst = 0; pk = 0; ptx = 0; pty = 0; pad = 0; pdt = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rrdy_mode)
        0: rsp_ready = 1'($urandom_range(0, 1));
        1: rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
      #1;
      if (rsp_valid && !pv) rise_cyc = cyc;
      if (pv && !pa && prst && rst) begin
        n_tests++;
        if (!rsp_valid || rsp_kind !== pk || rsp_TX !== ptx || rsp_TY !== pty ||
            rsp_addr !== pad || rsp_data !== pdt) begin
          n_fail++;
          $display("FAIL rsp_hold: valid %0b kind %0d addr %h (want held kind %0d addr %h)",
                   rsp_valid, rsp_kind, rsp_addr, pk, pad);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_tests++;
        n_rsp++;
        acc_cyc_q.push_back(cyc);
        last_tx = rsp_TX; last_ty = rsp_TY; last_src = rsp_src;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: kind %0d addr %h, want no response", rsp_kind, rsp_addr);
        end else begin
          e = exp_q.pop_front();
          if (rsp_kind !== e.kind || rsp_TX !== e.tx || rsp_TY !== e.ty || rsp_addr !== e.addr ||
              rsp_src !== {TY_P, TX_P} || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL rsp%0d: got kind %0d tx %0d ty %0d addr %h src %h data_lo %h; want kind %0d tx %0d ty %0d addr %h src %h data_lo %h",
                     n_rsp, rsp_kind, rsp_TX, rsp_TY, rsp_addr, rsp_src, rsp_data[63:0],
                     e.kind, e.tx, e.ty, e.addr, {TY_P, TX_P}, e.data[63:0]);
          end
        end
      end
      pv = rsp_valid; pa = rsp_valid && rsp_ready; prst = rst;
      pk = rsp_kind; ptx = rsp_TX; pty = rsp_TY; pad = rsp_addr; pdt = rsp_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int base, n, rsp0;
    logic [527:0] wd;
    rst = 1'b0; req_avail = 1'b0; req_data = '0; req_addr = '0; req_size = '0; req_src = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bank_req", 64'(bank_req), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_pop", 64'(req_pop), 64'd0);
    check("rst_rsp_src", 64'(rsp_src), 64'd0);
    check("rst_rsp_kind", 64'(rsp_kind), 64'd0);
    check("rst_bank_addr", 64'(bank_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single read with rvalid three cycles after acceptance.
    send(1'b0, 27'h0001234, {5'd3, 5'd5}, '0, 3);
    drain("single_rd");
    check("single_tx", 64'(last_tx), 64'd5);
    check("single_ty", 64'(last_ty), 64'd3);
    check("single_src", 64'(last_src), 64'({TY_P, TX_P}));
    check("single_lat", 64'(rise_cyc - acc_cyc), 64'd4);

    // Write, then read back through the bank.
    wd = rand528();
    rsp0 = n_rsp;
    send(1'b1, 27'h55, {5'd1, 5'd2}, wd, 0);
    drain("wr");
    check("wr_addr", 64'(last_wr_addr), 64'h55);
    check("wr_data", 64'(last_wr_data == wd), 64'd1);
`ifdef TILEXY_RSP_WRACK_EN
    check("wr_rsp_count", 64'(n_rsp - rsp0), 64'd1);
`else
    check("wr_rsp_count", 64'(n_rsp - rsp0), 64'd0);
`endif
    send(1'b0, 27'h55, {5'd4, 5'd6}, '0, 2);
    drain("wr_rd");

    // Timeout boundary: no rvalid -> ERR; rvalid on the last cycle -> RDATA.
    send(1'b0, 27'h300, {5'd7, 5'd8}, '0, 0);
    drain("tmo_err");
    check("tmo_err_lat", 64'(rise_cyc - acc_cyc), 64'(TMO + 1));
    send(1'b0, 27'h301, {5'd7, 5'd8}, '0, TMO);
    drain("tmo_edge");
    check("tmo_edge_lat", 64'(rise_cyc - acc_cyc), 64'(TMO + 1));

    // Bank backpressure: request and address held while bank_ready is low.
    brdy_mode = 2;
    send(1'b0, 27'h77, {5'd2, 5'd2}, '0, 2);
    n = 0;
    while (!bank_req && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_hold", 64'({bank_req, bank_we, bank_addr}), 64'({1'b1, 1'b0, 27'h77}));
    end
    @(negedge clk);
    brdy_mode = 1;
    drain("bp");

    // Fill: responses blocked, six requests offered; five absorbed.
    rrdy_mode = 2;
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 27'(100 + i), 10'(i * 33), '0, 1);
      end
    join_none
    repeat (20) @(negedge clk);
    #1;
    check("fill_popped", 64'(n_popped - base), 64'd5);
    check("fill_pop_low", 64'({req_avail, req_pop}), 64'b10);
    check("fill_busy", 64'(busy), 64'd1);
    @(negedge clk);
    acc_cyc_q.delete();
    rrdy_mode = 1;
    n = 0;
    while ((n_popped - base < 6 || exp_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
    drain("fill");
    check("fill_rsp_count", 64'(acc_cyc_q.size()), 64'd6);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      check("fill_b2b_gap", 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd3);

    // Reset while waiting for read data; the late rvalid must be ignored.
    base = n_bank_acc;
    send(1'b0, 27'h99, {5'd1, 5'd1}, '0, 5);
    n = 0;
    while (n_bank_acc == base && n < 100) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    delay_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("rst_wait_valid", 64'(rsp_valid), 64'd0);
    check("rst_wait_busy", 64'(busy), 64'd0);
    check("rst_wait_bank_req", 64'(bank_req), 64'd0);
    @(negedge clk);

    // Randomised traffic with random bank and return-mesh backpressure.
    brdy_mode = 0;
    rrdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      logic w;
      int d;
      w = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
      send(w, 27'($urandom_range(0, 7)), 10'($urandom), rand528(), d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain("random");
    check("random_delays_used", 64'(delay_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
